// File: rtl/morse_keyer.sv
// Drains ASCII characters from the UART receive buffer in FIFO order and keys
// them out as Morse timing on o_key.
module morse_keyer #(
  parameter int UNIT_CYCLES = 1440000,
  parameter int FETCH_WAIT  = 4
) (
  input  logic        i_clk_24,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [10:0] i_wr_addr,
  input  logic        i_wr_pulse,
  input  logic [6:0]  i_rd_data,
  output logic [10:0] o_rd_addr,
  output logic        o_key,
  output logic        o_busy,
  output logic        o_char_done,
  output logic [2:0]  o_dbg_state
);

  localparam int CW = $clog2(UNIT_CYCLES);
  localparam int FW = $clog2(FETCH_WAIT + 1);
  localparam logic [CW-1:0] CYC_LAST   = CW'(UNIT_CYCLES - 1);
  localparam logic [FW-1:0] FETCH_LAST = FW'(FETCH_WAIT);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MARK, S_ELEM_GAP, S_CHAR_GAP, S_WORD_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [FW-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [1:0]  unit_q, unit_d;
  logic [4:0]  pat_q, pat_d;
  logic [2:0]  rem_q, rem_d;
  logic [10:0] rd_addr_q, rd_addr_d;
  logic        key_q, key_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  info;
  logic [1:0]  seg_last;
  logic        unit_end, seg_end;

  // Returns {length[2:0], elements[4:0]}; elements left-aligned, MSB first, 1 = dash.
  function automatic logic [7:0] lookup(input logic [6:0] code);
    logic [6:0] up;
    up = (code >= 7'h61 && code <= 7'h7A) ? code - 7'd32 : code;
    case (up)
      7'h41: lookup = {3'd2, 5'b01000};  7'h42: lookup = {3'd4, 5'b10000};
      7'h43: lookup = {3'd4, 5'b10100};  7'h44: lookup = {3'd3, 5'b10000};
      7'h45: lookup = {3'd1, 5'b00000};  7'h46: lookup = {3'd4, 5'b00100};
      7'h47: lookup = {3'd3, 5'b11000};  7'h48: lookup = {3'd4, 5'b00000};
      7'h49: lookup = {3'd2, 5'b00000};  7'h4A: lookup = {3'd4, 5'b01110};
      7'h4B: lookup = {3'd3, 5'b10100};  7'h4C: lookup = {3'd4, 5'b01000};
      7'h4D: lookup = {3'd2, 5'b11000};  7'h4E: lookup = {3'd2, 5'b10000};
      7'h4F: lookup = {3'd3, 5'b11100};  7'h50: lookup = {3'd4, 5'b01100};
      7'h51: lookup = {3'd4, 5'b11010};  7'h52: lookup = {3'd3, 5'b01000};
      7'h53: lookup = {3'd3, 5'b00000};  7'h54: lookup = {3'd1, 5'b10000};
      7'h55: lookup = {3'd3, 5'b00100};  7'h56: lookup = {3'd4, 5'b00010};
      7'h57: lookup = {3'd3, 5'b01100};  7'h58: lookup = {3'd4, 5'b10010};
      7'h59: lookup = {3'd4, 5'b10110};  7'h5A: lookup = {3'd4, 5'b11000};
      7'h30: lookup = {3'd5, 5'b11111};  7'h31: lookup = {3'd5, 5'b01111};
      7'h32: lookup = {3'd5, 5'b00111};  7'h33: lookup = {3'd5, 5'b00011};
      7'h34: lookup = {3'd5, 5'b00001};  7'h35: lookup = {3'd5, 5'b00000};
      7'h36: lookup = {3'd5, 5'b10000};  7'h37: lookup = {3'd5, 5'b11000};
      7'h38: lookup = {3'd5, 5'b11100};  7'h39: lookup = {3'd5, 5'b11110};
      default: lookup = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    fetch_cnt_d = fetch_cnt_q;
    cyc_d       = cyc_q;
    unit_d      = unit_q;
    pat_d       = pat_q;
    rem_d       = rem_q;
    rd_addr_d   = rd_addr_q;
    done_d      = 1'b0;
    info        = lookup(i_rd_data);

    case (state_q)
      S_MARK:     seg_last = pat_q[4] ? 2'd2 : 2'd0;
      S_CHAR_GAP: seg_last = 2'd2;
      S_WORD_GAP: seg_last = 2'd3;
      default:    seg_last = 2'd0;
    endcase
    unit_end = (cyc_q == CYC_LAST);
    seg_end  = unit_end && (unit_q == seg_last);

    // Segment timing advances in every timed state; a state change below clears it.
    if (unit_end) begin
      cyc_d  = '0;
      unit_d = unit_q + 2'd1;
    end else begin
      cyc_d = cyc_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (i_en && (rd_addr_q != i_wr_addr)) begin
          state_d     = S_FETCH;
          fetch_cnt_d = '0;
        end
      end
      S_FETCH: begin
        if (i_wr_pulse)                    fetch_cnt_d = '0;
        else if (fetch_cnt_q == FETCH_LAST) state_d    = S_DECODE;
        else                               fetch_cnt_d = fetch_cnt_q + FW'(1);
      end
      S_DECODE: begin
        rd_addr_d = rd_addr_q + 11'd1;
        if (info[7:5] != 3'd0) begin
          pat_d   = info[4:0];
          rem_d   = info[7:5];
          state_d = S_MARK;
        end else if (i_rd_data == 7'h20) begin
          state_d = S_WORD_GAP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MARK: begin
        if (seg_end) begin
          if (rem_q > 3'd1) begin
            rem_d   = rem_q - 3'd1;
            pat_d   = {pat_q[3:0], 1'b0};
            state_d = S_ELEM_GAP;
          end else begin
            state_d = S_CHAR_GAP;
          end
        end
      end
      S_ELEM_GAP: if (seg_end) state_d = S_MARK;
      S_CHAR_GAP, S_WORD_GAP: begin
        if (seg_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      cyc_d  = '0;
      unit_d = '0;
    end
    key_d  = (state_d == S_MARK);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk_24) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      fetch_cnt_q <= '0;
      cyc_q       <= '0;
      unit_q      <= '0;
      pat_q       <= '0;
      rem_q       <= '0;
      rd_addr_q   <= '0;
      key_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      cyc_q       <= cyc_d;
      unit_q      <= unit_d;
      pat_q       <= pat_d;
      rem_q       <= rem_d;
      rd_addr_q   <= rd_addr_d;
      key_q       <= key_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_rd_addr   = rd_addr_q;
  assign o_key       = key_q;
  assign o_busy      = busy_q;
  assign o_char_done = done_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: a string-table Morse model predicts every cycle of
// {o_rd_addr, o_busy, o_char_done, o_key} for the character streams driven in.
module tb_morse_keyer;
  localparam int U  = 4;
  localparam int FW = 4;

  logic        clk = 1'b0;
  logic        rst, en, wr_pulse;
  logic [10:0] wr_addr;
  logic [6:0]  rd_data;
  logic [10:0] rd_addr;
  logic        key, busy, char_done;
  logic [2:0]  dbg_state;

  logic [6:0]  mem [2048];
  logic [13:0] exp_q [$];
  logic [10:0] m_rd;
  int          n_vec = 0;
  int          n_err = 0;

  string letters [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                          "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                          "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                          "-.--", "--.."};
  string digits [10] = '{"-----", ".----", "..---", "...--", "....-",
                         ".....", "-....", "--...", "---..", "----."};

  morse_keyer #(.UNIT_CYCLES(U), .FETCH_WAIT(FW)) dut (
    .i_clk_24(clk), .i_rst(rst), .i_en(en), .i_wr_addr(wr_addr),
    .i_wr_pulse(wr_pulse), .i_rd_data(rd_data), .o_rd_addr(rd_addr),
    .o_key(key), .o_busy(busy), .o_char_done(char_done), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  assign rd_data = mem[rd_addr];

  task automatic push_n(input int n, input logic b, input logic d, input logic k);
    for (int i = 0; i < n; i++) exp_q.push_back({m_rd, b, d, k});
  endtask

  // Reference: fetch lead (busy, old pointer), then the pattern, then one idle cycle.
  task automatic model_char(input byte c, input int extra_lead);
    string pat;
    bit    sup;
    bit    sp;
    sup = 1'b1;
    sp  = 1'b0;
    pat = "";
    if (c >= "A" && c <= "Z")      pat = letters[c - 65];
    else if (c >= "a" && c <= "z") pat = letters[c - 97];
    else if (c >= "0" && c <= "9") pat = digits[c - 48];
    else if (c == " ")             sp  = 1'b1;
    else                           sup = 1'b0;
    push_n(FW + 2 + extra_lead, 1'b1, 1'b0, 1'b0);
    m_rd = m_rd + 11'd1;
    if (!sup) begin
      push_n(1, 1'b0, 1'b0, 1'b0);
      return;
    end
    if (sp) begin
      push_n(4 * U, 1'b1, 1'b0, 1'b0);
    end else begin
      for (int i = 0; i < pat.len(); i++) begin
        if (i > 0) push_n(U, 1'b1, 1'b0, 1'b0);
        push_n((pat[i] == 8'h2D) ? 3 * U : U, 1'b1, 1'b0, 1'b1);
      end
      push_n(3 * U, 1'b1, 1'b0, 1'b0);
    end
    push_n(1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic put_char(input byte c);
    mem[wr_addr] = c[6:0];
    wr_addr      = wr_addr + 11'd1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; wr_pulse = 1'b0; wr_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({rd_addr, busy, char_done, key} !== 14'd0) begin
      n_err++;
      $display("FAIL reset: got %h expected 0000", {rd_addr, busy, char_done, key});
    end
    rst = 1'b0;
    m_rd = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({rd_addr, busy, char_done, key} !== 14'd0) begin
        n_err++;
        $display("FAIL idle_after_reset cyc %0d: got %h expected 0000", i,
                 {rd_addr, busy, char_done, key});
      end
    end
  endtask

  task automatic test_stream(input string name, input string s);
    logic [13:0] e;
    @(posedge clk); #1;
    for (int i = 0; i < s.len(); i++) begin
      model_char(s[i], 0);
      put_char(s[i]);
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({rd_addr, busy, char_done, key} !== e) begin
        n_err++;
        $display("FAIL %s sample %0d: got %h expected %h", name, k,
                 {rd_addr, busy, char_done, key}, e);
      end
    end
  endtask

  task automatic test_random;
    string uns = "#!@?.~";
    string s;
    byte   c;
    for (int b = 0; b < 4; b++) begin
      s = "";
      for (int i = 0; i < int'($urandom_range(3, 6)); i++) begin
        case ($urandom_range(0, 4))
          0:       c = byte'(65 + $urandom_range(0, 25));
          1:       c = byte'(97 + $urandom_range(0, 25));
          2:       c = byte'(48 + $urandom_range(0, 9));
          3:       c = " ";
          default: c = uns[$urandom_range(0, 5)];
        endcase
        s = {s, string'(c)};
      end
      test_stream("random", s);
    end
  endtask

  task automatic test_enable;
    logic [13:0] e;
    @(posedge clk); #1;
    model_char("M", 0);
    put_char("M");
    put_char("K");
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({rd_addr, busy, char_done, key} !== e) begin
        n_err++;
        $display("FAIL enable_hold sample %0d: got %h expected %h", k,
                 {rd_addr, busy, char_done, key}, e);
      end
      if (k == 10) en = 1'b0;
    end
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({rd_addr, busy, char_done, key} !== {m_rd, 3'b000}) begin
        n_err++;
        $display("FAIL enable_idle cyc %0d: got %h expected %h", i,
                 {rd_addr, busy, char_done, key}, {m_rd, 3'b000});
      end
    end
    en = 1'b1;
    model_char("K", 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({rd_addr, busy, char_done, key} !== e) begin
        n_err++;
        $display("FAIL enable_resume sample %0d: got %h expected %h", k,
                 {rd_addr, busy, char_done, key}, e);
      end
    end
  endtask

  task automatic test_reset_mid_dash;
    int waited;
    @(posedge clk); #1;
    put_char("T");
    waited = 0;
    while (key !== 1'b1 && waited < 30) begin
      @(posedge clk); #1;
      waited++;
    end
    n_vec++;
    if (waited >= 30) begin
      n_err++;
      $display("FAIL reset_mid_dash_start: got key %b expected 1", key);
    end
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    wr_addr = '0;
    @(posedge clk); #1;
    n_vec++;
    if ({rd_addr, busy, char_done, key} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_mid_dash: got %h expected 0000", {rd_addr, busy, char_done, key});
    end
    rst = 1'b0;
    m_rd = '0;
    repeat (10) @(posedge clk);
    #1;
    n_vec++;
    if ({rd_addr, busy, char_done, key} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_mid_dash_idle: got %h expected 0000", {rd_addr, busy, char_done, key});
    end
  endtask

  task automatic test_stall_wrap;
    logic [13:0] e;
    int waited;
    @(posedge clk); #1;
    for (int i = 0; i < 2047; i++) put_char("#");
    waited = 0;
    while (!(rd_addr === 11'd2047 && busy === 1'b0) && waited < 20000) begin
      @(posedge clk); #1;
      waited++;
    end
    n_vec++;
    if (waited >= 20000) begin
      n_err++;
      $display("FAIL unsupported_drain: got rd_addr %0d expected 2047", rd_addr);
    end
    m_rd = 11'd2047;
    model_char("E", 3);
    model_char("T", 0);
    put_char("E");
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({rd_addr, busy, char_done, key} !== e) begin
        n_err++;
        $display("FAIL stall_wrap sample %0d: got %h expected %h", k,
                 {rd_addr, busy, char_done, key}, e);
      end
      if (k == 2) begin
        wr_pulse = 1'b1;
        put_char("T");
      end
      if (k == 3) wr_pulse = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 7'h00;
    test_reset;
    test_stream("char_e", "E");
    test_stream("s_then_t", "St");
    test_stream("a_space_b", "A B#Z");
    test_random;
    test_enable;
    test_reset_mid_dash;
    test_stall_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
